// File: rtl/bcd_up_timer_if.sv
// bcd_up_timer_if: control and display bundle for bcd_up_timer.
// The LIM port exists only when LIMIT_EN is defined.
interface bcd_up_timer_if #(parameter int DIGITS = 4);
  logic                start;
  logic                stop;
  logic                clear;
  logic                LDn;
  logic [4*DIGITS-1:0] D;
  logic [4*DIGITS-1:0] Q;
  logic                CO;
  logic                tick;
  logic                running;
  logic                done;
`ifdef LIMIT_EN
  logic [4*DIGITS-1:0] LIM;

  modport master (output start, stop, clear, LDn, D, LIM,
                  input  Q, CO, tick, running, done);
  modport slave  (input  start, stop, clear, LDn, D, LIM,
                  output Q, CO, tick, running, done);
`else
  modport master (output start, stop, clear, LDn, D,
                  input  Q, CO, tick, running, done);
  modport slave  (input  start, stop, clear, LDn, D,
                  output Q, CO, tick, running, done);
`endif
endinterface

// File: rtl/bcd_up_timer.sv
// bcd_up_timer: cascaded BCD stopwatch counter with run/hold control and tick prescaler.
// Optional feature macro LIMIT_EN adds a LIM compare input and a DONE state.
module bcd_up_timer #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 100
) (
  input logic           CP,
  input logic           CR,
  bcd_up_timer_if.slave bus
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
`ifdef LIMIT_EN
  localparam logic [1:0] S_DONE = 2'd3;
`endif

  logic [1:0]    state;
  logic [W-1:0]  q;
  logic [PW-1:0] presc;
  logic          co;
  logic          tick;
  logic [W-1:0]  inc_q;
  logic          all_nines;
  logic [W-1:0]  load_val;
  logic          carry;

  // Ripple the increment through the digits; a digit advances only while every lower digit is 9.
  always_comb begin
    inc_q = q;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (q[4*i +: 4] == 4'd9) begin
          inc_q[4*i +: 4] = 4'd0;
        end else begin
          inc_q[4*i +: 4] = q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    all_nines = carry;
  end

  always_comb begin
    load_val = bus.D;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.D[4*i +: 4] > 4'd9) load_val[4*i +: 4] = 4'd9;
    end
  end

`ifdef LIMIT_EN
  logic done_r;
  assign bus.done = done_r;
`else
  assign bus.done = 1'b0;
`endif

  always_ff @(posedge CP) begin
    if (CR) begin
      q     <= '0;
      presc <= '0;
      co    <= 1'b0;
      tick  <= 1'b0;
      state <= S_IDLE;
`ifdef LIMIT_EN
      done_r <= 1'b0;
`endif
    end else begin
      co   <= 1'b0;
      tick <= 1'b0;
      if (!bus.LDn) begin
        q     <= load_val;
        presc <= '0;
`ifdef LIMIT_EN
        if (state == S_DONE) begin
          state  <= S_HOLD;
          done_r <= 1'b0;
        end
`endif
      end else if (bus.clear) begin
        q     <= '0;
        presc <= '0;
        state <= S_IDLE;
`ifdef LIMIT_EN
        done_r <= 1'b0;
`endif
      end else begin
        case (state)
          // A simultaneous start+stop from IDLE parks in HOLD since stop wins.
          S_IDLE: begin
            if (bus.start) begin
              state <= bus.stop ? S_HOLD : S_RUN;
              presc <= '0;
            end
          end
          S_RUN: begin
            if (bus.stop) begin
              state <= S_HOLD;
            end else if (presc == LAST) begin
              presc <= '0;
              tick  <= 1'b1;
              q     <= inc_q;
              co    <= all_nines;
`ifdef LIMIT_EN
              if (inc_q == bus.LIM) begin
                state  <= S_DONE;
                done_r <= 1'b1;
              end
`endif
            end else begin
              presc <= presc + 1'b1;
            end
          end
          S_HOLD: begin
            if (bus.start && !bus.stop) state <= S_RUN;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.Q       = q;
  assign bus.CO      = co;
  assign bus.tick    = tick;
  assign bus.running = (state == S_RUN);

endmodule

// File: tb/tb_bcd_up_timer.sv
// tb_bcd_up_timer: table vectors plus multi-cycle sequences for bcd_up_timer (DIGITS=2, TICK_DIV=4).
// The limit sequence is included only when LIMIT_EN is defined.
module tb_bcd_up_timer;
  localparam int DIGITS   = 2;
  localparam int TICK_DIV = 4;

  logic cp = 1'b0;
  logic cr = 1'b0;

  always #5 cp = ~cp;

  bcd_up_timer_if #(.DIGITS(DIGITS)) bus ();

  bcd_up_timer #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV)) dut (
    .CP  (cp),
    .CR  (cr),
    .bus (bus)
  );

  typedef struct {
    logic       cr;
    logic       start;
    logic       stop;
    logic       clear;
    logic       ldn;
    logic [7:0] d;
    logic [7:0] q;
    logic       co;
    logic       tick;
    logic       running;
    logic       done;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[9];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic c, input logic s, input logic p, input logic cl,
                              input logic l, input logic [7:0] dv, input logic [7:0] qv,
                              input logic cov, input logic tv, input logic rv, input logic dnv);
    vec_t v;
    v.cr = c; v.start = s; v.stop = p; v.clear = cl; v.ldn = l; v.d = dv;
    v.q = qv; v.co = cov; v.tick = tv; v.running = rv; v.done = dnv;
    return v;
  endfunction

  function automatic logic [7:0] bcd(input int n);
    return 8'(((n / 10) % 10) * 16 + (n % 10));
  endfunction

  task automatic compare(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_output(input string tag);
    vec_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: scoreboard empty, got Q=%h, expected an entry", tag, bus.Q);
    end else begin
      e = sb.pop_front();
      compare({tag, ".Q"},       bus.Q,       e.q);
      compare({tag, ".CO"},      bus.CO,      e.co);
      compare({tag, ".tick"},    bus.tick,    e.tick);
      compare({tag, ".running"}, bus.running, e.running);
      compare({tag, ".done"},    bus.done,    e.done);
    end
  endtask

  task automatic apply_stimulus(input vec_t v, input string tag);
    cr        = v.cr;
    bus.start = v.start;
    bus.stop  = v.stop;
    bus.clear = v.clear;
    bus.LDn   = v.ldn;
    bus.D     = v.d;
    sb.push_back(v);
    @(posedge cp);
    #1;
    check_output(tag);
  endtask

  task automatic do_reset();
    apply_stimulus(mk(1, 0, 0, 0, 1, 8'h00, 8'h00, 0, 0, 0, 0), "reset");
  endtask

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.clear = 1'b0; bus.LDn = 1'b1; bus.D = '0;
`ifdef LIMIT_EN
    bus.LIM = 8'h50;
`endif
    tbl[0] = mk(1, 0, 0, 0, 1, 8'h00, 8'h00, 0, 0, 0, 0);
    tbl[1] = mk(0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 0, 0, 0);
    tbl[2] = mk(0, 0, 0, 0, 0, 8'hAF, 8'h99, 0, 0, 0, 0);
    tbl[3] = mk(0, 1, 1, 0, 1, 8'h00, 8'h99, 0, 0, 0, 0);
    tbl[4] = mk(0, 0, 0, 0, 1, 8'h00, 8'h99, 0, 0, 0, 0);
    tbl[5] = mk(0, 1, 0, 0, 1, 8'h00, 8'h99, 0, 0, 1, 0);
    tbl[6] = mk(0, 1, 0, 1, 1, 8'h00, 8'h00, 0, 0, 0, 0);
    tbl[7] = mk(0, 0, 1, 0, 1, 8'h00, 8'h00, 0, 0, 0, 0);
    tbl[8] = mk(0, 0, 0, 1, 0, 8'h5A, 8'h59, 0, 0, 0, 0);

    @(posedge cp);
    #1;
    for (int i = 0; i < 9; i++) apply_stimulus(tbl[i], $sformatf("tbl%0d", i));

    // Reset then a quiet idle period.
    do_reset();
    for (int i = 0; i < 10; i++)
      apply_stimulus(mk(0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 0, 0, 0), "idle");

    // Free run: one tick every fourth cycle, 10 ticks reach 10.
    do_reset();
    apply_stimulus(mk(0, 1, 0, 0, 1, 8'h00, 8'h00, 0, 0, 1, 0), "run_start");
    for (int k = 1; k <= 40; k++)
      apply_stimulus(mk(0, 0, 0, 0, 1, 8'h00, bcd(k / 4), 0, (k % 4) == 0, 1, 0),
                     $sformatf("run%0d", k));
    for (int k = 41; k <= 43; k++)
      apply_stimulus(mk(0, 0, 0, 0, 1, 8'h00, 8'h10, 0, 0, 1, 0), "run_pre_cr");
    apply_stimulus(mk(1, 1, 0, 0, 1, 8'h00, 8'h00, 0, 0, 0, 0), "cr_over_tick");

    // Wrap from 99 to 00 with a single-cycle carry.
    do_reset();
    apply_stimulus(mk(0, 0, 0, 0, 0, 8'h98, 8'h98, 0, 0, 0, 0), "load98");
    apply_stimulus(mk(0, 1, 0, 0, 1, 8'h00, 8'h98, 0, 0, 1, 0), "wrap_start");
    for (int k = 1; k <= 9; k++)
      apply_stimulus(mk(0, 0, 0, 0, 1, 8'h00, (k < 4) ? 8'h98 : (k < 8) ? 8'h99 : 8'h00,
                        k == 8, (k == 4) || (k == 8), 1, 0), $sformatf("wrap%0d", k));

    // Hold keeps the prescaler phase; a load mid-run restarts it.
    do_reset();
    apply_stimulus(mk(0, 1, 0, 0, 1, 8'h00, 8'h00, 0, 0, 1, 0), "hold_start");
    for (int k = 1; k <= 2; k++)
      apply_stimulus(mk(0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 0, 1, 0), "hold_pre");
    apply_stimulus(mk(0, 0, 1, 0, 1, 8'h00, 8'h00, 0, 0, 0, 0), "hold_stop");
    for (int k = 0; k < 7; k++)
      apply_stimulus(mk(0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 0, 0, 0), "hold_wait");
    apply_stimulus(mk(0, 1, 0, 0, 1, 8'h00, 8'h00, 0, 0, 1, 0), "resume");
    apply_stimulus(mk(0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 0, 1, 0), "resume1");
    apply_stimulus(mk(0, 0, 0, 0, 1, 8'h00, 8'h01, 0, 1, 1, 0), "resume2");
    apply_stimulus(mk(0, 0, 0, 0, 0, 8'h42, 8'h42, 0, 0, 1, 0), "load_run");
    for (int k = 1; k <= 3; k++)
      apply_stimulus(mk(0, 0, 0, 0, 1, 8'h00, 8'h42, 0, 0, 1, 0), "post_load");
    apply_stimulus(mk(0, 0, 0, 0, 1, 8'h00, 8'h43, 0, 1, 1, 0), "post_load_tick");

`ifdef LIMIT_EN
    // Limit stop at 03, start ignored while done, clear releases.
    bus.LIM = 8'h03;
    do_reset();
    apply_stimulus(mk(0, 1, 0, 0, 1, 8'h00, 8'h00, 0, 0, 1, 0), "lim_start");
    for (int k = 1; k <= 12; k++)
      apply_stimulus(mk(0, 0, 0, 0, 1, 8'h00, bcd(k / 4), 0, (k % 4) == 0, k < 12, k == 12),
                     $sformatf("lim%0d", k));
    apply_stimulus(mk(0, 1, 0, 0, 1, 8'h00, 8'h03, 0, 0, 0, 1), "lim_start_ign");
    for (int k = 0; k < 3; k++)
      apply_stimulus(mk(0, 0, 0, 0, 1, 8'h00, 8'h03, 0, 0, 0, 1), "lim_hold");
    apply_stimulus(mk(0, 0, 0, 1, 1, 8'h00, 8'h00, 0, 0, 0, 0), "lim_clear");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
